// File: rtl/redraw_pkg.sv
// Shared definitions for the change-driven redraw scheduler: FSM encoding,
// default timing constants and the completed-pass counter width.
package redraw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_PAINT,
        ST_HOLD
    } state_t;

    localparam int DEF_HOLDOFF = 16;
    localparam int DEF_TIMEOUT = 76800;
    localparam int PASS_CNT_W  = 16;

endpackage

// File: rtl/chan_change_det.sv
// One monitored channel: snapshot register, change comparator and dirty bit.
// A detected change (or a retry request) wins over the clear issued at ARM.
module chan_change_det #(
    parameter int CH_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH_W-1:0] din,
    input  logic            clr,
    input  logic            set,
    output logic            dirty
);

    logic [CH_W-1:0] snap;
    logic            changed;

    assign changed = (din != snap);

    always_ff @(posedge clk) begin
        if (rst) begin
            // Snapshot zero plus dirty forces a full redraw after every reset.
            snap  <= '0;
            dirty <= 1'b1;
        end else begin
            if (changed) begin
                snap <= din;
            end
            if (changed || set) begin
                dirty <= 1'b1;
            end else if (clr) begin
                dirty <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/redraw_scheduler.sv
// Change-driven redraw controller: one painter pass per batch of channel changes,
// with hold-off spacing. Optional pass watchdog enabled by macro REDRAW_TIMEOUT_EN.
module redraw_scheduler
    import redraw_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 64,
    parameter int HOLDOFF = DEF_HOLDOFF,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     Clck,
    input  logic                     Reset,
    input  logic [NUM_CH*CH_W-1:0]   ch_data,
    input  logic                     paint_done,
    output logic                     paint_en,
    output logic [NUM_CH-1:0]        redraw_mask,
    output logic                     busy,
    output logic [PASS_CNT_W-1:0]    pass_count,
    output logic                     timeout_flag
);

    localparam int HCNT_W = $clog2(HOLDOFF + 2);
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLDOFF);

    if (TIMEOUT < 1 || HOLDOFF < 0) begin : g_bad_cfg
        $error("redraw_scheduler: TIMEOUT must be >= 1 and HOLDOFF >= 0");
    end

    state_t              state;
    state_t              state_nxt;
    logic [NUM_CH-1:0]   dirty;
    logic [NUM_CH-1:0]   retry;
    logic [HCNT_W-1:0]   hold_cnt;
    logic                arm;
    logic                pass_ok;
    logic                wd_expire;

    assign arm = (state == ST_ARM);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        chan_change_det #(
            .CH_W (CH_W)
        ) u_det (
            .clk   (Clck),
            .rst   (Reset),
            .din   (ch_data[i*CH_W +: CH_W]),
            .clr   (arm),
            .set   (retry[i]),
            .dirty (dirty[i])
        );
    end

    always_comb begin
        state_nxt = state;
        pass_ok   = 1'b0;
        case (state)
            ST_IDLE:  if (|dirty) state_nxt = ST_ARM;
            ST_ARM:   state_nxt = ST_PAINT;
            ST_PAINT: begin
                if (paint_done) begin
                    pass_ok   = 1'b1;
                    state_nxt = ST_HOLD;
                end else if (wd_expire) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD:  if (hold_cnt == HOLD_LAST) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge Clck) begin
        if (Reset) begin
            state       <= ST_IDLE;
            paint_en    <= 1'b0;
            busy        <= 1'b0;
            redraw_mask <= '0;
            pass_count  <= '0;
            hold_cnt    <= '0;
        end else begin
            state    <= state_nxt;
            paint_en <= (state_nxt == ST_PAINT);
            busy     <= (state_nxt != ST_IDLE);
            if (arm) begin
                redraw_mask <= dirty;
            end
            if (pass_ok) begin
                pass_count <= pass_count + 1'b1;
            end
            hold_cnt <= (state == ST_HOLD) ? hold_cnt + 1'b1 : '0;
        end
    end

`ifdef REDRAW_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd_cnt;

    assign wd_expire = (state == ST_PAINT) && !paint_done && (wd_cnt == WD_LAST);
    // An abandoned pass puts its channels back in the dirty set for a retry.
    assign retry     = wd_expire ? redraw_mask : '0;

    always_ff @(posedge Clck) begin
        if (Reset) begin
            wd_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            wd_cnt <= (state == ST_PAINT) ? wd_cnt + 1'b1 : '0;
            if (wd_expire) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`else
    assign wd_expire    = 1'b0;
    assign retry        = '0;
    assign timeout_flag = 1'b0;
`endif

endmodule
